// File: rtl/frame_sync.sv
// frame_sync: serial frame marker hunt/verify/lock with flywheel, byte deframing into a 4-deep FWFT FIFO.
// Define FSYNC_SOFT_EN to flag bytes with two or more weak soft-decision bits via m_erase.
module frame_sync #(
  parameter logic [15:0] SYNC_WORD = 16'hA5C3,
  parameter int FRAME_BYTES = 8,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       d_bb,
  input  logic [1:0] d_q2,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_erase,
  output logic       locked,
  output logic [1:0] state,
  output logic       overflow
);
  typedef enum logic [1:0] {HUNT = 2'b00, VERIFY = 2'b01, LOCKED = 2'b10} st_t;
  localparam logic [9:0] F = 10'(16 + 8 * FRAME_BYTES);
  localparam logic [9:0] PL = 10'(8 * FRAME_BYTES);
`ifdef FSYNC_SOFT_EN
  localparam int W = 10;
`else
  localparam int W = 9;
`endif
  st_t st;
  logic [15:0] sreg, sreg_n;
  logic [9:0] bitcnt, bc_n;
  logic [3:0] good_cnt, miss_cnt;
  logic mark, match, push, pop, full, wr;
  logic [W-1:0] din;
  logic [W-1:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  assign sreg_n = {sreg[14:0], d_bb};
  assign bc_n = bitcnt + 10'd1;
  assign match = sreg_n == SYNC_WORD;
  assign mark = sample_en && st != HUNT && bc_n == F;
  assign push = sample_en && st == LOCKED && bc_n[2:0] == 3'd0 && bc_n <= PL;
  assign full = cnt == 3'd4;
  assign pop = m_valid && m_ready;
  assign wr = push && (!full || pop);
  assign m_valid = cnt != 3'd0;
  assign m_data = mem[rp][7:0];
  assign m_sof = m_valid && mem[rp][8];
  assign locked = st == LOCKED;
  assign state = st;
`ifdef FSYNC_SOFT_EN
  logic [3:0] wk, wk_n;
  assign wk_n = wk + {3'd0, d_q2 == 2'b01 || d_q2 == 2'b10};
  assign din = {wk_n >= 4'd2, bc_n == 10'd8, sreg_n[7:0]};
  assign m_erase = m_valid && mem[rp][9];
  // Weak count restarts on every byte boundary, including marker bytes.
  always_ff @(posedge clk)
    if (rst || st == HUNT) wk <= '0;
    else if (sample_en) wk <= bc_n[2:0] == 3'd0 ? 4'd0 : wk_n;
`else
  logic unused_q2;
  assign unused_q2 = ^d_q2;
  assign din = {bc_n == 10'd8, sreg_n[7:0]};
  assign m_erase = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      st <= HUNT;
      sreg <= '0;
      bitcnt <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
    end else if (sample_en) begin
      sreg <= sreg_n;
      if (st == HUNT) begin
        if (match) begin
          st <= VERIFY;
          bitcnt <= '0;
          good_cnt <= 4'd1;
          miss_cnt <= '0;
        end
      end else if (!mark) bitcnt <= bc_n;
      else begin
        bitcnt <= '0;
        if (st == VERIFY) begin
          if (match) begin
            good_cnt <= good_cnt + 4'd1;
            if (good_cnt + 4'd1 == 4'(LOCK_CNT)) st <= LOCKED;
          end else st <= HUNT;
        end else if (match) miss_cnt <= '0;
        else begin
          miss_cnt <= miss_cnt + 4'd1;
          if (miss_cnt + 4'd1 == 4'(LOSS_CNT)) st <= HUNT;
        end
      end
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(wr) - 3'(pop);
    end
endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: directed frame streams, expected bytes queued by the driver and checked by a monitor.
module tb_frame_sync;
  logic clk = 0, rst = 1, sample_en = 0, d_bb = 0, m_ready = 1;
  logic [1:0] d_q2 = 2'b00;
  logic m_valid, m_sof, m_erase, locked, overflow;
  logic [7:0] m_data;
  logic [1:0] state;
  int total = 0, passed = 0, ovf_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic [7:0] pl[8];
  logic [7:0] wm[8];
  always #5 clk = ~clk;
  frame_sync dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .d_bb(d_bb), .d_q2(d_q2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .m_erase(m_erase), .locked(locked), .state(state), .overflow(overflow)
  );
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_byte: got %0h expected none", {m_erase, m_sof, m_data});
      end else begin
        e = exp_q.pop_front();
        chk("byte", {m_erase, m_sof, m_data}, e);
      end
    end
  end
  task automatic send_bit(input logic b, input logic [1:0] q);
    sample_en = 1; d_bb = b; d_q2 = q;
    @(posedge clk); #1;
    sample_en = 0; d_q2 = 2'b00;
    @(posedge clk); #1;
  endtask
  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i], 2'b00);
  endtask
  task automatic send_byte(input logic [7:0] v, input logic sof, input logic exp, input logic [7:0] mask);
    logic er;
`ifdef FSYNC_SOFT_EN
    er = $countones(mask) >= 2;
`else
    er = 1'b0;
`endif
    if (exp) exp_q.push_back({er, sof, v});
    for (int i = 7; i >= 0; i--) send_bit(v[i], mask[i] ? 2'b01 : 2'b00);
  endtask
  task automatic frame(input logic [15:0] mk, input int n);
    for (int k = 0; k < 8; k++) send_byte(pl[k], k == 0, k < n, wm[k]);
    send_word(mk);
  endtask
  task automatic drain(input string nm);
    repeat (6) @(posedge clk);
    #1;
    chk(nm, exp_q.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 8; k++) begin
      pl[k] = 8'(k);
      wm[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_overflow", overflow, 0);
    rst = 0;
    send_word(16'hA5C3);
    chk("verify_state", state, 1);
    frame(16'hA5C3, 0);
    chk("lock_state", state, 2);
    chk("lock_locked", locked, 1);
    frame(16'hA5C3, 8);
    drain("drain_first");
    m_ready = 0;
    ovf_cnt = 0;
    frame(16'hA5C3, 4);
    chk("ovf_pulses", ovf_cnt, 4);
    chk("held_valid", m_valid, 1);
    chk("held_data", m_data, 0);
    chk("held_sof", m_sof, 1);
    m_ready = 1;
    drain("drain_bp");
`ifdef FSYNC_SOFT_EN
    wm[3] = 8'b0001_0100;
    frame(16'hA5C3, 8);
    wm[3] = 8'b0000_0100;
    frame(16'hA5C3, 8);
    wm[3] = 8'h00;
    drain("drain_soft");
`endif
    frame(16'hA5C2, 8);
    chk("miss1_locked", locked, 1);
    frame(16'hA5C3, 8);
    chk("good_locked", locked, 1);
    frame(16'hA5C2, 8);
    chk("lossa_locked", locked, 1);
    frame(16'hA5C2, 8);
    chk("lossb_locked", locked, 1);
    frame(16'hA5C2, 8);
    chk("lossc_locked", locked, 0);
    chk("lossc_state", state, 0);
    drain("drain_loss");
    send_word(16'hA5C3);
    chk("reverify_state", state, 1);
    frame(16'hA5C3, 0);
    chk("relock", locked, 1);
    pl[0] = 8'hA5;
    pl[1] = 8'hC3;
    frame(16'hA5C3, 8);
    chk("fake_locked", locked, 1);
    pl[0] = 8'h00;
    pl[1] = 8'h01;
    frame(16'hA5C3, 8);
    chk("fake_state", state, 2);
    drain("drain_fake");
    send_byte(8'h00, 1, 1, 8'h00);
    send_byte(8'h01, 0, 1, 8'h00);
    for (int i = 7; i >= 4; i--) send_bit(pl[2][i], 2'b00);
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("midrst_state", state, 0);
    chk("midrst_valid", m_valid, 0);
    for (int i = 3; i >= 0; i--) send_bit(pl[2][i], 2'b00);
    for (int k = 3; k < 8; k++) send_byte(pl[k], 0, 0, 8'h00);
    chk("postrst_state", state, 0);
    send_word(16'hA5C3);
    chk("postrst_verify", state, 1);
    drain("drain_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
